// File: rtl/signed_bcd_conv.sv
// Iterative signed/unsigned 8-bit binary to 3-digit BCD converter (double dabble).
// One bit per clock; result and sign held until the next conversion completes.
module signed_bcd_conv #(
   parameter bit SIGNED_MODE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] din,
   output logic       busy,
   output logic       done,
   output logic       sign,
   output logic [3:0] hund,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t      state_reg, state_next;
   logic [19:0] work_reg, work_next;
   logic [2:0]  cnt_reg, cnt_next;
   logic        neg_reg, neg_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        sign_reg, sign_next;
   logic [3:0]  hund_reg, hund_next;
   logic [3:0]  tens_reg, tens_next;
   logic [3:0]  ones_reg, ones_next;

   logic        in_neg;
   logic [7:0]  mag;
   logic [11:0] bcd_adj;
   logic [19:0] shifted;

   // 8'h80 negates to 8'h80, which read unsigned is the required magnitude 128
   assign in_neg = din[7] & SIGNED_MODE;
   assign mag    = in_neg ? (~din + 8'd1) : din;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         logic [3:0] nib;
         assign nib = work_reg[8 + 4*gi +: 4];
         assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
      end
   endgenerate

   // Hundreds never exceeds 2, so the adjusted top bit is never shifted out
   assign shifted = {bcd_adj[10:0], work_reg[7:0], 1'b0};

   always_comb begin
      state_next = state_reg;
      work_next  = work_reg;
      cnt_next   = cnt_reg;
      neg_next   = neg_reg;
      sign_next  = sign_reg;
      hund_next  = hund_reg;
      tens_next  = tens_reg;
      ones_next  = ones_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               neg_next   = in_neg;
               work_next  = {12'h000, mag};
               cnt_next   = 3'd0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            work_next = shifted;
            cnt_next  = cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
               sign_next  = neg_reg;
               hund_next  = shifted[19:16];
               tens_next  = shifted[15:12];
               ones_next  = shifted[11:8];
               state_next = FINISH;
            end
         end
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
      done_next = (state_next == FINISH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         work_reg  <= 20'h0;
         cnt_reg   <= 3'd0;
         neg_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         sign_reg  <= 1'b0;
         hund_reg  <= 4'h0;
         tens_reg  <= 4'h0;
         ones_reg  <= 4'h0;
      end else begin
         state_reg <= state_next;
         work_reg  <= work_next;
         cnt_reg   <= cnt_next;
         neg_reg   <= neg_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         sign_reg  <= sign_next;
         hund_reg  <= hund_next;
         tens_reg  <= tens_next;
         ones_reg  <= ones_next;
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign sign = sign_reg;
   assign hund = hund_reg;
   assign tens = tens_reg;
   assign ones = ones_reg;

endmodule

// File: tb/tb_signed_bcd_conv.sv
// Directed bench for signed_bcd_conv: one signed and one unsigned instance on a shared clock/reset.
module tb_signed_bcd_conv;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_start = 1'b0, u_start = 1'b0;
   logic [7:0] s_din = 8'h00, u_din = 8'h00;
   logic       s_busy, s_done, s_sign, u_busy, u_done, u_sign;
   logic [3:0] s_hund, s_tens, s_ones, u_hund, u_tens, u_ones;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   signed_bcd_conv #(.SIGNED_MODE(1'b1)) u_signed (
      .clk(clk), .rst_n(rst_n), .start(s_start), .din(s_din),
      .busy(s_busy), .done(s_done), .sign(s_sign),
      .hund(s_hund), .tens(s_tens), .ones(s_ones)
   );

   signed_bcd_conv #(.SIGNED_MODE(1'b0)) u_unsigned (
      .clk(clk), .rst_n(rst_n), .start(u_start), .din(u_din),
      .busy(u_busy), .done(u_done), .sign(u_sign),
      .hund(u_hund), .tens(u_tens), .ones(u_ones)
   );

   // Result packed as 16'hSHTO: sign, hundreds, tens, ones
   function automatic logic [15:0] res(input bit u);
      return u ? {3'b000, u_sign, u_hund, u_tens, u_ones}
               : {3'b000, s_sign, s_hund, s_tens, s_ones};
   endfunction

   function automatic logic [15:0] bd(input bit u);
      return u ? {14'h0, u_busy, u_done} : {14'h0, s_busy, s_done};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic convert(input bit u, input logic [7:0] d, input logic [15:0] exp, input string tag);
      logic [15:0] prev;
      int lat;
      prev = res(u);
      @(negedge clk);
      if (u) begin u_start = 1'b1; u_din = d; end
      else   begin s_start = 1'b1; s_din = d; end
      @(posedge clk);
      @(negedge clk);
      if (u) begin u_start = 1'b0; u_din = ~d; end
      else   begin s_start = 1'b0; s_din = ~d; end
      chk({tag, "_busy_dn"}, bd(u), 16'h2);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 4) chk({tag, "_hold"}, res(u), prev);
         if (bd(u)[0]) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_lat"}, 16'(lat), 16'd8);
      chk({tag, "_res"}, res(u), exp);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_idle"}, bd(u), 16'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int ndone;
      int first_at;
      int busy_after;
      int at_n [2];
      logic [15:0] r [2];

      // Reset
      repeat (3) @(negedge clk);
      chk("rst_hold_s", {bd(0)[1:0], res(0)}, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_s_bd", bd(0), 16'h0);
      chk("rst_s_res", res(0), 16'h0);
      chk("rst_u_bd", bd(1), 16'h0);
      chk("rst_u_res", res(1), 16'h0);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_done || u_done) ndone++;
      end
      chk("rst_no_done", 16'(ndone), 16'd0);

      // Signed mode
      convert(1'b0, 8'hFB, 16'h1005, "s_FB");
      convert(1'b0, 8'h7F, 16'h0127, "s_7F");
      convert(1'b0, 8'h80, 16'h1128, "s_80");
      convert(1'b0, 8'h00, 16'h0000, "s_00");

      // Unsigned mode
      convert(1'b1, 8'hFF, 16'h0255, "u_FF");
      convert(1'b1, 8'h80, 16'h0128, "u_80");

      // START while busy is ignored
      @(negedge clk);
      s_start = 1'b1; s_din = 8'h0C;
      @(posedge clk);
      @(negedge clk);
      s_start = 1'b0;
      ndone = 0; first_at = 0; busy_after = -1; r[0] = 16'hFFFF;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 2) begin s_start = 1'b1; s_din = 8'h63; end
         if (n == 3) s_start = 1'b0;
         if (n == 9) busy_after = int'(s_busy);
         if (s_done) begin
            ndone++;
            if (ndone == 1) begin first_at = n; r[0] = res(0); end
         end
      end
      chk("ign_ndone", 16'(ndone), 16'd1);
      chk("ign_at", 16'(first_at), 16'd8);
      chk("ign_res", r[0], 16'h0012);
      chk("ign_busy_after", 16'(busy_after), 16'd0);

      // Continuous START, alternating operands
      @(negedge clk);
      s_start = 1'b1; s_din = 8'hF6;
      @(posedge clk);
      @(negedge clk);
      s_din = 8'h2A;
      ndone = 0; at_n[0] = 0; at_n[1] = 0; r[0] = 16'hFFFF; r[1] = 16'hFFFF;
      for (int n = 1; n <= 19; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 10) s_din = 8'hF6;
         if (n == 19) s_start = 1'b0;
         if (s_done) begin
            if (ndone < 2) begin at_n[ndone] = n; r[ndone] = res(0); end
            ndone++;
         end
      end
      chk("cont_ndone", 16'(ndone), 16'd2);
      chk("cont_at0", 16'(at_n[0]), 16'd8);
      chk("cont_at1", 16'(at_n[1]), 16'd18);
      chk("cont_res0", r[0], 16'h1010);
      chk("cont_res1", r[1], 16'h0042);
      repeat (3) @(negedge clk);
      chk("cont_idle", bd(0), 16'h0);

      // Asynchronous reset mid-conversion
      @(negedge clk);
      s_start = 1'b1; s_din = 8'h55;
      @(posedge clk);
      @(negedge clk);
      s_start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_s_bd", bd(0), 16'h0);
      chk("mid_rst_s_res", res(0), 16'h0);
      chk("mid_rst_u_res", res(1), 16'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (s_done) ndone++;
      end
      chk("mid_rst_no_done", 16'(ndone), 16'd0);
      convert(1'b0, 8'h9C, 16'h1100, "s_9C");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/signed_bcd_conv.md
Name: signed_bcd_conv

Overview:
- Sequential converter that sits downstream of the 8-bit two's-complement negation stage.
- Takes an 8-bit two's-complement (or unsigned) value and produces a sign flag plus three BCD digits (hundreds/tens/ones) for the display driver.
- Uses an iterative shift-add-3 (double-dabble) datapath with a START/BUSY/DONE handshake: one bit per clock, fixed latency.

Parameters:
- SIGNED_MODE, 1, 1: DIN is two's complement, range -128..127. 0: DIN is unsigned, range 0..255, and SIGN is always 0.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  conversion request; sampled only in IDLE.
- DIN  input  8  value to convert; captured on the accepting edge.
- BUSY  output  1  high while a conversion is in progress (SHIFT or FINISH).
- DONE  output  1  one-cycle pulse; result valid.
- SIGN  output  1  1 when the captured value is negative (SIGNED_MODE=1 only).
- HUND  output  4  BCD hundreds digit, 0..2.
- TENS  output  4  BCD tens digit, 0..9.
- ONES  output  4  BCD ones digit, 0..9.

Behaviour:
- Clock and reset: single clock CLK. Reset is asynchronous and active-low on RST_N.
- While RST_N=0:
  - state=IDLE, shift counter=0, internal shift register cleared.
  - BUSY=0, DONE=0, SIGN=0, HUND=TENS=ONES=4'h0.
- Reset mid-conversion aborts the conversion immediately. No DONE is produced, and outputs return to 0.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - Entered when START=1 is sampled at edge k.
  - Sign: captured sign = DIN[7] & SIGNED_MODE.
  - Magnitude (8-bit unsigned):
    - Negative: ~DIN + 1, modulo 256.
    - Otherwise: DIN.
    - 8'h80 gives magnitude 128, with no overflow.
  - Actions at edge k: load the 20-bit working register {12'h0, mag}, set cnt=0, go to SHIFT.
- SHIFT (edges k+1 .. k+8):
  - Each edge:
    - Add 3 to each BCD nibble of the working register that is >=5.
    - Then shift the whole register left by 1.
    - Increment cnt.
  - At the edge where cnt==7 (edge k+8):
    - Perform the final shift.
    - Load SIGN/HUND/TENS/ONES from the shifted result.
    - Go to FINISH.
- FINISH:
  - DONE=1 for exactly this one cycle. It is sampled high at edge k+9.
  - Edge k+9 returns to IDLE.
- Latency: START is accepted at edge k, and DONE is sampled high at edge k+9. Throughput is one conversion per 10 cycles.
- BUSY is 1 in SHIFT and FINISH, and 0 in IDLE. It is registered, and is first high after edge k.
- START and DIN while BUSY=1 (including the FINISH cycle) are ignored. There is no queueing.
- START held high continuously re-triggers on each IDLE cycle, giving back-to-back conversions at a 10-cycle period.
- DIN changes after the accepting edge do not affect the result in progress.
- Output hold: SIGN/HUND/TENS/ONES hold the last result until the next conversion completes at its final SHIFT edge. They are not cleared by START.
- Zero: DIN=0 gives SIGN=0 and 0/0/0. Negative zero cannot occur.
- Digit limits: HUND never exceeds 2, and no nibble ever exceeds 9.

Test Plan:
- Reset: RST_N=0, then release -> BUSY=0, DONE=0, SIGN=0, HUND/TENS/ONES=0/0/0. No DONE within 20 idle cycles.
- SIGNED_MODE=1, sign coverage:
  - DIN=8'hFB with a START pulse -> DONE sampled high exactly 9 edges after acceptance; SIGN=1, digits 0/0/5.
  - DIN=8'h7F -> SIGN=0, digits 1/2/7.
  - DIN=8'h80 -> SIGN=1, digits 1/2/8.
  - DIN=8'h00 -> SIGN=0, digits 0/0/0.
- SIGNED_MODE=0, unsigned range:
  - DIN=8'hFF -> SIGN=0, digits 2/5/5.
  - DIN=8'h80 -> SIGN=0, digits 1/2/8.
- Start ignored while busy: START with DIN=8'h0C. At acceptance+3, pulse START with DIN=8'h63 -> one DONE only, with digits 0/1/2. BUSY drops after edge k+9. No second DONE follows.
- Continuous START, alternating DIN 8'hF6 / 8'h2A at each acceptance -> DONE every 10 cycles. Results in order: SIGN=1 digits 0/1/0, then SIGN=0 digits 0/4/2.
- Reset mid-operation: assert RST_N=0 asynchronously at acceptance+4 -> BUSY and outputs go 0 immediately, with no DONE. A following START with DIN=8'h9C -> SIGN=1, digits 1/0/0.
